// File: rtl/jacobi_result_streamer_pkg.sv
// Shared Jacobi constants, readout FSM state type and the packed-diagonal address helper.
package jacobi_result_streamer_pkg;

  localparam int JACOBI_N                  = 8;
  localparam int JACOBI_OUTPUT_WORD_WIDTH  = 20;
  localparam int JACOBI_ADDR_WIDTH         = 7;
  localparam int JACOBI_V_OFFSET           = 36;
  localparam int JACOBI_N_OUTPUT_DATA      = 72;
  localparam int JACOBI_LOG2_N_OUTPUT_DATA = 7;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_DIAG,
    RS_VEC,
    RS_DRAIN
  } jacobi_rs_state_t;

  // Address of element (i,i) in row-major packed upper-triangular storage.
  function automatic int jacobi_diag_addr(input int i);
    return i * JACOBI_N - (i * (i - 1)) / 2;
  endfunction

endpackage

// File: rtl/jacobi_out_skid.sv
// Two-entry fall-through FIFO: an arriving word goes straight to the output when the buffer is empty.
module jacobi_out_skid #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] buf_mem [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         has_head;
  logic         push_buf;
  logic         pop_buf;

  assign has_head  = (count_reg != 2'd0);
  assign out_valid = has_head | in_valid;
  assign out_data  = has_head ? buf_mem[rd_ptr_reg] : (in_valid ? in_data : '0);
  assign pop_buf   = has_head & out_ready;
  // A word bypasses storage only if nothing is queued ahead of it and it is taken this cycle.
  assign push_buf  = in_valid & (has_head | ~out_ready);
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (push_buf) buf_mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_buf) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_buf)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push_buf} - {1'b0, pop_buf};
    end
  end

endmodule

// File: rtl/jacobi_result_streamer.sv
// Reads eigenvalues (packed diagonal) then eigenvectors from Jacobi memory and streams them out.
module jacobi_result_streamer
  import jacobi_result_streamer_pkg::*;
#(
  parameter int N        = JACOBI_N,
  parameter int WORD_W   = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int ADDR_W   = JACOBI_ADDR_WIDTH,
  parameter int V_OFFSET = JACOBI_V_OFFSET,
  parameter int N_OUT    = JACOBI_N_OUTPUT_DATA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sel,
  output logic              out_last
);

  localparam int CNT_W = $clog2(N_OUT);
  localparam int NW    = $clog2(N);
  localparam logic [ADDR_W-1:0] V_BASE = ADDR_W'(V_OFFSET - N);

  jacobi_rs_state_t  state_reg, state_next;
  logic [CNT_W-1:0]  rd_cnt_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [ADDR_W-1:0] addr_cur;
  logic [ADDR_W-1:0] diag_lut [N];
  logic              inflight_reg;
  logic              infl_sel_reg;
  logic              infl_last_reg;
  logic              done_reg, done_next;
  logic [1:0]        buf_count;
  logic              pop;
  logic              reading;
  logic              credit_ok;
  logic              issue;
  logic              diag_end;
  logic              final_issue;
  logic [WORD_W+1:0] skid_out;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_diag
      assign diag_lut[gi] = ADDR_W'(jacobi_diag_addr(gi));
    end
  endgenerate

  assign reading     = (state_reg == RS_DIAG) || (state_reg == RS_VEC);
  assign pop         = out_valid & out_ready;
  // Buffer entries plus the read in flight, less this cycle's handshake, must leave a free slot.
  assign credit_ok   = ({1'b0, buf_count} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop});
  assign issue       = reading & credit_ok;
  assign diag_end    = (rd_cnt_reg == CNT_W'(N - 1));
  assign final_issue = (rd_cnt_reg == CNT_W'(N_OUT - 1));
  assign addr_cur    = (state_reg == RS_DIAG) ? diag_lut[rd_cnt_reg[NW-1:0]]
                                              : V_BASE + ADDR_W'(rd_cnt_reg);

  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? addr_cur : addr_hold_reg;
  assign busy        = (state_reg != RS_IDLE);
  assign done        = done_reg;

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      RS_IDLE:  if (start) state_next = RS_DIAG;
      RS_DIAG:  if (issue && diag_end) state_next = RS_VEC;
      RS_VEC:   if (issue && final_issue) state_next = RS_DRAIN;
      RS_DRAIN: begin
        if (pop && out_last) begin
          state_next = RS_IDLE;
          done_next  = 1'b1;
        end
      end
      default:  state_next = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RS_IDLE;
      done_reg      <= 1'b0;
      rd_cnt_reg    <= '0;
      addr_hold_reg <= '0;
      inflight_reg  <= 1'b0;
      infl_sel_reg  <= 1'b0;
      infl_last_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= done_next;
      inflight_reg <= issue;
      if (state_reg == RS_IDLE && start) begin
        rd_cnt_reg <= '0;
      end else if (issue) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
      if (issue) begin
        addr_hold_reg <= addr_cur;
        infl_sel_reg  <= (state_reg == RS_VEC);
        infl_last_reg <= final_issue;
      end
    end
  end

  jacobi_out_skid #(.W(WORD_W + 2)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight_reg),
    .in_data   ({infl_sel_reg, infl_last_reg, mem_rd_data}),
    .out_valid (out_valid),
    .out_data  (skid_out),
    .out_ready (out_ready),
    .count     (buf_count)
  );

  assign out_sel  = skid_out[WORD_W+1];
  assign out_last = skid_out[WORD_W];
  assign out_data = skid_out[WORD_W-1:0];

endmodule

// File: tb/tb_jacobi_result_streamer.sv
// Scoreboard bench: expected words queued per readout, an independent monitor pops and compares.
module tb_jacobi_result_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_rd_en;
  logic [6:0]  mem_rd_addr;
  logic [19:0] mem_rd_data = '0;
  logic [19:0] out_data;
  logic        out_valid, out_sel, out_last;
  logic        out_ready = 1'b0;

  jacobi_result_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sel     (out_sel),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] mem [128];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: word w < 8 is eigenvalue i=w at i*8 - i(i-1)/2, the rest are V entries from 36.
  function automatic logic [21:0] exp_word(input int w);
    int a;
    a = (w < 8) ? (w * 8 - (w * (w - 1)) / 2) : (36 + w - 8);
    return {(w >= 8), (w == 71), mem[a]};
  endfunction

  logic [21:0] exp_q [$];
  int word_cnt, done_cnt, first_valid_cyc, first_rd_cyc, issued, accepted;
  bit          stall_prev = 0;
  logic [21:0] stall_pl;
  int          ready_mode = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 40) < 10) ? 1'b0 : (cyc % 2 == 1);
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  always @(negedge clk) begin
    logic [21:0] e;
    if (!rst_n) begin
      stall_prev = 0;
      issued     = 0;
      accepted   = 0;
    end else begin
      if (mem_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        issued++;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_payload", 64'({out_sel, out_last, out_data}), 64'(stall_pl));
      end
      if (out_valid && out_ready) begin
        accepted++;
        word_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected none", {out_sel, out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          check($sformatf("word%0d", word_cnt), 64'({out_sel, out_last, out_data}), 64'(e));
        end
      end
      check("outstanding_le2", 64'(issued - accepted <= 2), 64'd1);
      stall_prev = out_valid && !out_ready;
      stall_pl   = {out_sel, out_last, out_data};
      if (done) done_cnt++;
    end
  end

  task automatic begin_readout(output int s);
    @(posedge clk); #1;
    for (int w = 0; w < 72; w++) exp_q.push_back(exp_word(w));
    word_cnt = 0; done_cnt = 0; first_valid_cyc = -1; first_rd_cyc = -1;
    issued = 0; accepted = 0;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_readout(input bit extra_starts, input bit ready_high, input bit settle);
    int s;
    int k;
    begin_readout(s);
    k = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1;
      k++;
      start = extra_starts && ((cyc - s) == 5 || (cyc - s) == 40);
    end
    start = 1'b0;
    if (k >= 3000) check("done_timeout", 64'd0, 64'd1);
    check("first_rd_latency", 64'(first_rd_cyc - s), 64'd1);
    check("first_valid_latency", 64'(first_valid_cyc - s), 64'd2);
    if (ready_high) check("done_cycle", 64'(cyc - s), 64'd74);
    check("busy_low_at_done", 64'(busy), 64'd0);
    check("word_count", 64'(word_cnt), 64'd72);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    if (settle) begin
      repeat (4) @(negedge clk);
      check("single_done", 64'(done_cnt), 64'd1);
    end
  endtask

  initial begin
    int s;
    int k;
    for (int a = 0; a < 128; a++) mem[a] = 20'(a);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, mem_rd_en, mem_rd_addr, out_data, out_valid, out_sel, out_last}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identity memory, ready always high.
    ready_mode = 0;
    run_readout(0, 1, 1);

    // Toggling ready with a long stall window.
    ready_mode = 1;
    run_readout(0, 0, 1);

    // Stray start pulses during readout.
    ready_mode = 0;
    run_readout(1, 1, 1);

    // Abort by reset at word 20, then a fresh readout.
    for (int a = 0; a < 128; a++) mem[a] = 20'($urandom);
    begin_readout(s);
    k = 0;
    while (word_cnt < 20 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reach_word20", 64'(word_cnt >= 20), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", 64'({busy, done, mem_rd_en, mem_rd_addr, out_data, out_valid, out_sel, out_last}), 64'd0);
    exp_q.delete();
    done_cnt = 0;
    repeat (4) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_stays_idle", 64'({busy, out_valid}), 64'd0);
    run_readout(0, 1, 1);

    // Back-to-back readouts.
    run_readout(0, 1, 0);
    run_readout(0, 1, 1);

    // Data extremes at both ends, random ready.
    mem[0]  = 20'h80000;
    mem[99] = 20'h7FFFF;
    ready_mode = 2;
    run_readout(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
